// File: rtl/regfile_writeback_if.sv
// rtl/regfile_writeback_if.sv - ALU, load and register-file write-port signals
// for the writeback controller.
interface regfile_writeback_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              RegWrite;
  logic [ADDR_W-1:0] RD;
  logic [DATA_W-1:0] WriteData;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  alu_ready, RegWrite, RD, WriteData
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output alu_ready, RegWrite, RD, WriteData
  );
endinterface

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - merges ALU and load results onto the single
// register-file write port, buffering ALU results behind loads in order.
module regfile_writeback #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1,
  localparam int NREG  = 1 << ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_writeback_if.slave   bus,
  output logic [NREG-1:0]      pending,
  output logic [CNT_W-1:0]     fifo_count
);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] fifo_rd_q   [DEPTH];
  logic [ADDR_W-1:0] fifo_rd_d   [DEPTH];
  logic [DATA_W-1:0] fifo_data_q [DEPTH];
  logic [DATA_W-1:0] fifo_data_d [DEPTH];
  logic [DEPTH-1:0]  kill_q, kill_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] rd_out_q, rd_out_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic [DEPTH-1:0]  occ;
  logic              alu_ready;
  logic              load_wr, empty, head_kill, head_pop, head_wr;
  logic              alu_take, bypass, push;

  // Slot i is occupied when its distance from the head is below the count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_occ
    logic [PTR_W-1:0] off;
    assign off    = PTR_W'(i) - rd_ptr_q;
    assign occ[i] = {1'b0, off} < count_q;
  end

  always_comb begin
    alu_ready = reset && (count_q != FULL);
    load_wr   = bus.mem_valid && (bus.mem_rd != '0);
    empty     = (count_q == '0);
    head_kill = kill_q[rd_ptr_q];
    head_pop  = !empty && (head_kill || !load_wr);
    head_wr   = !empty && !head_kill && !load_wr;
    alu_take  = bus.alu_valid && alu_ready && (bus.alu_rd != '0);
    bypass    = alu_take && empty && !load_wr;
    push      = alu_take && !bypass;
  end

  always_comb begin
    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;
    kill_d      = kill_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    reg_write_d = 1'b0;
    rd_out_d    = rd_out_q;
    wdata_d     = wdata_q;

    if (load_wr) begin
      reg_write_d = 1'b1;
      rd_out_d    = bus.mem_rd;
      wdata_d     = bus.mem_data;
    end else if (head_wr) begin
      reg_write_d = 1'b1;
      rd_out_d    = fifo_rd_q[rd_ptr_q];
      wdata_d     = fifo_data_q[rd_ptr_q];
    end else if (bypass) begin
      reg_write_d = 1'b1;
      rd_out_d    = bus.alu_rd;
      wdata_d     = bus.alu_data;
    end

    // Older buffered ALU results must not overwrite a newer load value.
    for (int i = 0; i < DEPTH; i++) begin
      if (load_wr && occ[i] && (fifo_rd_q[i] == bus.mem_rd)) kill_d[i] = 1'b1;
    end

    // The entry pushed this cycle is younger than the load, so it stays live.
    if (push) begin
      fifo_rd_d[wr_ptr_q]   = bus.alu_rd;
      fifo_data_d[wr_ptr_q] = bus.alu_data;
      kill_d[wr_ptr_q]      = 1'b0;
      wr_ptr_d              = wr_ptr_q + 1'b1;
    end
    if (head_pop) rd_ptr_d = rd_ptr_q + 1'b1;

    count_d = count_q + CNT_W'(push) - CNT_W'(head_pop);
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occ[i] && !kill_q[i]) pending[fifo_rd_q[i]] = 1'b1;
    end
    pending[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_rd_q[i]   <= '0;
        fifo_data_q[i] <= '0;
      end
      kill_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      reg_write_q <= 1'b0;
      rd_out_q    <= '0;
      wdata_q     <= '0;
    end else begin
      fifo_rd_q   <= fifo_rd_d;
      fifo_data_q <= fifo_data_d;
      kill_q      <= kill_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      reg_write_q <= reg_write_d;
      rd_out_q    <= rd_out_d;
      wdata_q     <= wdata_d;
    end
  end

  assign bus.alu_ready = alu_ready;
  assign bus.RegWrite  = reg_write_q;
  assign bus.RD        = rd_out_q;
  assign bus.WriteData = wdata_q;
  assign fifo_count    = count_q;
endmodule
